immgen_pipe: RTL and testbench



---
 rtl/immgen_pipe.sv | 191 +++++++++++++++++++
 tb/tb_immgen_pipe.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/immgen_pipe.sv
// -----------------------------------------------------------------------------
// immgen_pipe
// Pipelined RV immediate generator for the decode stage. Classifies the base
// formats (I, S, B, U, J), builds the XLEN-wide sign-extended immediate, flags
// unsupported encodings and carries a sideband tag. Valid/ready on both sides
// with an output register plus one skid register, so upstream and downstream
// can stall independently while sustaining one instruction per cycle.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     upstream handshake (in_ready is registered)
//   in_inst, in_tag       raw instruction word and sideband tag
//   out_valid/out_ready   downstream handshake
//   out_imm, out_fmt      immediate and format (0 none, 1 I, 2 S, 3 B, 4 U, 5 J)
//   out_illegal, out_tag  illegal flag and tag of the output entry
//   illegal_cnt, cnt_clr  saturating illegal-accept counter and its clear
// -----------------------------------------------------------------------------
module immgen_pipe #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_cnt,
    input  logic             cnt_clr
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Format classification from the major opcode; anything without the
    // 32-bit encoding marker in bits [1:0] is illegal.
    function automatic logic [2:0] dec_fmt(input logic [31:0] inst);
        logic [2:0] f;
        f = FMT_NONE;
        if (inst[1:0] == 2'b11) begin
            case (inst[6:2])
                5'b00000, 5'b00011, 5'b00100,
                5'b11001, 5'b11100:  f = FMT_I;
                5'b00110:            f = (XLEN == 64) ? FMT_I : FMT_NONE;
                5'b01000:            f = FMT_S;
                5'b11000:            f = FMT_B;
                5'b00101, 5'b01101:  f = FMT_U;
                5'b11011:            f = FMT_J;
                default:             f = FMT_NONE;
            endcase
        end else begin
            f = FMT_NONE;
        end
        return f;
    endfunction

    // Immediate is assembled at 64 bits and truncated, which keeps the
    // replication counts constant for both XLEN values.
    function automatic logic [XLEN-1:0] dec_imm(input logic [31:0] inst,
                                                input logic [2:0]  fmt);
        logic [63:0] w;
        case (fmt)
            FMT_I:   w = {{52{inst[31]}}, inst[31:20]};
            FMT_S:   w = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   w = {{51{inst[31]}}, inst[31], inst[7], inst[30:25],
                          inst[11:8], 1'b0};
            FMT_U:   w = {{32{inst[31]}}, inst[31:12], 12'b0};
            FMT_J:   w = {{43{inst[31]}}, inst[31], inst[19:12], inst[20],
                          inst[30:21], 1'b0};
            default: w = 64'd0;
        endcase
        return w[XLEN-1:0];
    endfunction

    logic [2:0]       dec_fmt_s;
    logic [XLEN-1:0]  dec_imm_s;
    logic             dec_ill_s;
    logic             accept_s;
    logic             load_out_s;

    logic             out_valid_r;
    logic [XLEN-1:0]  out_imm_r;
    logic [2:0]       out_fmt_r;
    logic             out_ill_r;
    logic [TAG_W-1:0] out_tag_r;
    logic             skid_valid_r;
    logic [XLEN-1:0]  skid_imm_r;
    logic [2:0]       skid_fmt_r;
    logic             skid_ill_r;
    logic [TAG_W-1:0] skid_tag_r;
    logic             in_ready_r;
    logic [CNT_W-1:0] cnt_r;

    // Combinational decode of the incoming word and handshake qualifiers.
    always_comb begin
        dec_fmt_s  = dec_fmt(in_inst);
        dec_ill_s  = (dec_fmt_s == FMT_NONE);
        dec_imm_s  = dec_imm(in_inst, dec_fmt_s);
        accept_s   = in_valid & in_ready_r;
        // Output register may take a new entry when empty or being drained.
        load_out_s = ~out_valid_r | out_ready;
    end

    // Output register, skid register, registered in_ready and illegal counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_imm_r    <= '0;
            out_fmt_r    <= FMT_NONE;
            out_ill_r    <= 1'b0;
            out_tag_r    <= '0;
            skid_valid_r <= 1'b0;
            skid_imm_r   <= '0;
            skid_fmt_r   <= FMT_NONE;
            skid_ill_r   <= 1'b0;
            skid_tag_r   <= '0;
            in_ready_r   <= 1'b1;
            cnt_r        <= '0;
        end else begin
            if (load_out_s) begin
                if (skid_valid_r) begin
                    // Older skid entry moves forward; a new accept backfills it.
                    out_valid_r  <= 1'b1;
                    out_imm_r    <= skid_imm_r;
                    out_fmt_r    <= skid_fmt_r;
                    out_ill_r    <= skid_ill_r;
                    out_tag_r    <= skid_tag_r;
                    skid_valid_r <= accept_s;
                    in_ready_r   <= ~accept_s;
                    if (accept_s) begin
                        skid_imm_r <= dec_imm_s;
                        skid_fmt_r <= dec_fmt_s;
                        skid_ill_r <= dec_ill_s;
                        skid_tag_r <= in_tag;
                    end
                end else if (accept_s) begin
                    out_valid_r <= 1'b1;
                    out_imm_r   <= dec_imm_s;
                    out_fmt_r   <= dec_fmt_s;
                    out_ill_r   <= dec_ill_s;
                    out_tag_r   <= in_tag;
                    in_ready_r  <= 1'b1;
                end else begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            end else if (accept_s) begin
                // Output is holding; park the new entry and close the input.
                skid_valid_r <= 1'b1;
                skid_imm_r   <= dec_imm_s;
                skid_fmt_r   <= dec_fmt_s;
                skid_ill_r   <= dec_ill_s;
                skid_tag_r   <= in_tag;
                in_ready_r   <= 1'b0;
            end else begin
                in_ready_r <= ~skid_valid_r;
            end

            // Clear wins over a coincident illegal accept.
            if (cnt_clr) begin
                cnt_r <= '0;
            end else if (accept_s && dec_ill_s && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_imm     = out_imm_r;
    assign out_fmt     = out_fmt_r;
    assign out_illegal = out_ill_r;
    assign out_tag     = out_tag_r;
    assign illegal_cnt = cnt_r;

endmodule

// File: tb/tb_immgen_pipe.sv
// -----------------------------------------------------------------------------
// tb_immgen_pipe
// Drives an XLEN=64 instance and an XLEN=32/CNT_W=2 instance with identical
// stimulus and compares both against a FIFO-of-entries reference model whose
// immediates are computed arithmetically from the instruction fields.
// -----------------------------------------------------------------------------
module tb_immgen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [63:0] in_tag;
    logic        out_ready;
    logic        cnt_clr;

    logic        in_ready_a, out_valid_a, out_illegal_a;
    logic [63:0] out_imm_a;
    logic [2:0]  out_fmt_a;
    logic [63:0] out_tag_a;
    logic [15:0] illegal_cnt_a;

    logic        in_ready_b, out_valid_b, out_illegal_b;
    logic [31:0] out_imm_b;
    logic [2:0]  out_fmt_b;
    logic [15:0] out_tag_b;
    logic [1:0]  illegal_cnt_b;

    always #5 clk = ~clk;

    immgen_pipe #(.XLEN(64), .TAG_W(64), .CNT_W(16)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_imm(out_imm_a), .out_fmt(out_fmt_a),
        .out_illegal(out_illegal_a), .out_tag(out_tag_a),
        .illegal_cnt(illegal_cnt_a), .cnt_clr(cnt_clr)
    );

    immgen_pipe #(.XLEN(32), .TAG_W(16), .CNT_W(2)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_inst(in_inst), .in_tag(in_tag[15:0]), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_imm(out_imm_b), .out_fmt(out_fmt_b),
        .out_illegal(out_illegal_b), .out_tag(out_tag_b),
        .illegal_cnt(illegal_cnt_b), .cnt_clr(cnt_clr)
    );

    typedef struct {
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic        ill64;
        logic [63:0] imm32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [63:0] tag;
    } ent_t;

    ent_t q[$];
    int   cnt64;
    int   cnt32;
    bit   was_rst;
    bit   last_acc;
    int   errors = 0;
    int   checks = 0;

    // Interpret a field value as a two's-complement number of 'bits' bits.
    function automatic longint sx(input longint raw, input int bits);
        if (raw >= (longint'(1) << (bits - 1))) return raw - (longint'(1) << bits);
        else return raw;
    endfunction

    function automatic void ref_dec(input logic [31:0] i, input int xlen,
                                    output logic [63:0] imm, output logic [2:0] fmt,
                                    output logic ill);
        longint v;
        fmt = 3'd0;
        if (i[1:0] == 2'b11) begin
            case (i[6:2])
                5'b00000, 5'b00011, 5'b00100, 5'b11001, 5'b11100: fmt = 3'd1;
                5'b00110: fmt = (xlen == 64) ? 3'd1 : 3'd0;
                5'b01000: fmt = 3'd2;
                5'b11000: fmt = 3'd3;
                5'b00101, 5'b01101: fmt = 3'd4;
                5'b11011: fmt = 3'd5;
                default:  fmt = 3'd0;
            endcase
        end
        case (fmt)
            3'd1: v = sx(longint'(i[31:20]), 12);
            3'd2: v = sx(longint'({i[31:25], i[11:7]}), 12);
            3'd3: v = sx(longint'({i[31], i[7], i[30:25], i[11:8]}), 12) * 2;
            3'd4: v = sx(longint'(i[31:12]), 20) * 4096;
            3'd5: v = sx(longint'({i[31], i[19:12], i[20], i[30:21]}), 20) * 2;
            default: v = 0;
        endcase
        ill = (fmt == 3'd0);
        imm = (xlen == 64) ? 64'(v) : {32'd0, 32'(v)};
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic check_all();
        bit v;
        v = (q.size() > 0);
        chk("out_valid64", 64'(out_valid_a), 64'(v));
        chk("out_valid32", 64'(out_valid_b), 64'(v));
        chk("in_ready64", 64'(in_ready_a), 64'(q.size() < 2));
        chk("in_ready32", 64'(in_ready_b), 64'(q.size() < 2));
        chk("cnt64", 64'(illegal_cnt_a), 64'(cnt64));
        chk("cnt32", 64'(illegal_cnt_b), 64'(cnt32));
        if (v) begin
            chk("imm64", out_imm_a, q[0].imm64);
            chk("fmt64", 64'(out_fmt_a), 64'(q[0].fmt64));
            chk("ill64", 64'(out_illegal_a), 64'(q[0].ill64));
            chk("tag64", out_tag_a, q[0].tag);
            chk("imm32", 64'(out_imm_b), q[0].imm32);
            chk("fmt32", 64'(out_fmt_b), 64'(q[0].fmt32));
            chk("ill32", 64'(out_illegal_b), 64'(q[0].ill32));
            chk("tag32", 64'(out_tag_b), {48'd0, q[0].tag[15:0]});
        end else if (was_rst) begin
            chk("rst_payload64", out_imm_a | 64'(out_fmt_a) | 64'(out_illegal_a) | out_tag_a, 64'd0);
            chk("rst_payload32", 64'(out_imm_b) | 64'(out_fmt_b) | 64'(out_illegal_b) | 64'(out_tag_b), 64'd0);
        end
    endtask

    // One clock: model the edge from the inputs currently applied, then check.
    task automatic cycle();
        bit   acc;
        ent_t e;
        acc = in_valid && (q.size() < 2);
        ref_dec(in_inst, 64, e.imm64, e.fmt64, e.ill64);
        ref_dec(in_inst, 32, e.imm32, e.fmt32, e.ill32);
        e.tag = in_tag;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            cnt64    = 0;
            cnt32    = 0;
            was_rst  = 1'b1;
            last_acc = 1'b0;
        end else begin
            was_rst  = 1'b0;
            last_acc = acc;
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back(e);
            if (cnt_clr) begin
                cnt64 = 0;
                cnt32 = 0;
            end else if (acc) begin
                if (e.ill64 && cnt64 < 65535) cnt64++;
                if (e.ill32 && cnt32 < 3) cnt32++;
            end
        end
        #1;
        check_all();
    endtask

    task automatic send(input logic [31:0] inst, input logic [63:0] tag);
        in_valid = 1'b1;
        in_inst  = inst;
        in_tag   = tag;
        for (int k = 0; k < 50; k++) begin
            cycle();
            if (last_acc) break;
        end
        chk("send_accepted", 64'(last_acc), 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    logic [4:0]  ops[14];
    logic [31:0] r;

    initial begin
        ops = '{5'b00000, 5'b00011, 5'b00100, 5'b11001, 5'b11100, 5'b00110, 5'b01000,
                5'b11000, 5'b00101, 5'b01101, 5'b11011, 5'b00001, 5'b01100, 5'b11111};
        rst_n = 1'b0; in_valid = 1'b0; in_inst = 32'd0; in_tag = 64'd0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();

        // I format
        send(32'hFFF00093, 64'h1000);
        chk("addi_imm", out_imm_a, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_fmt", 64'(out_fmt_a), 64'd1);
        chk("addi_tag", out_tag_a, 64'h1000);
        idle(1);

        // S then B back to back
        send(32'hFE112E23, 64'h2000);
        chk("sw_imm", out_imm_a, 64'hFFFF_FFFF_FFFF_FFFC);
        send(32'hFE000CE3, 64'h2004);
        chk("beq_imm", out_imm_a, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("beq_fmt", 64'(out_fmt_a), 64'd3);

        // U, J and OP-IMM-32 width dependence
        send(32'h800002B7, 64'h3000);
        chk("lui_imm", out_imm_a, 64'hFFFF_FFFF_8000_0000);
        send(32'h0010006F, 64'h3004);
        chk("jal_imm", out_imm_a, 64'h800);
        chk("jal_fmt", 64'(out_fmt_a), 64'd5);
        send(32'h0000001B, 64'h3008);
        chk("opimm32_ill_x32", 64'(out_illegal_b), 64'd1);
        chk("opimm32_fmt_x32", 64'(out_fmt_b), 64'd0);
        chk("opimm32_fmt_x64", 64'(out_fmt_a), 64'd1);
        idle(2);

        // Backpressure: A in output, B in skid, C held
        out_ready = 1'b0;
        send(32'h00100093, 64'hA);
        send(32'h00200093, 64'hB);
        chk("bp_in_ready", 64'(in_ready_a), 64'd0);
        in_inst = 32'h00300093; in_tag = 64'hC;
        cycle();
        cycle();
        chk("bp_hold_tag", out_tag_a, 64'hA);
        out_ready = 1'b1;
        cycle();
        chk("bp_second_tag", out_tag_a, 64'hB);
        send(32'h00300093, 64'hC);
        chk("bp_third_tag", out_tag_a, 64'hC);
        idle(2);

        // Illegal instructions and counter
        cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
        send(32'h00000000, 64'h40);
        send(32'h00000010, 64'h41);
        chk("ill_imm", out_imm_a, 64'd0);
        chk("ill_cnt2", 64'(illegal_cnt_a), 64'd2);
        for (int k = 0; k < 3; k++) send(32'hFFFFFF7F, 64'h50 + 64'(k));
        chk("sat_cnt32", 64'(illegal_cnt_b), 64'd3);
        chk("cnt64_5", 64'(illegal_cnt_a), 64'd5);
        cnt_clr = 1'b1;
        send(32'h00000000, 64'h60);
        cnt_clr = 1'b0;
        chk("clr_prio", 64'(illegal_cnt_a), 64'd0);
        idle(2);

        // Reset with both entries full
        out_ready = 1'b0;
        send(32'h00000000, 64'h70);
        send(32'h00500093, 64'h71);
        in_valid = 1'b1; in_inst = 32'h00600093; in_tag = 64'h72;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        in_valid = 1'b0;
        chk("rst_out_valid", 64'(out_valid_a), 64'd0);
        chk("rst_in_ready", 64'(in_ready_a), 64'd1);
        chk("rst_cnt", 64'(illegal_cnt_a), 64'd0);
        out_ready = 1'b1;
        send(32'h00700093, 64'h80);
        chk("post_rst_tag", out_tag_a, 64'h80);
        idle(1);
        chk("post_rst_empty", 64'(out_valid_a), 64'd0);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            r = $urandom;
            r[6:2] = ops[$urandom_range(0, 13)];
            r[1:0] = ($urandom_range(0, 9) == 0) ? 2'b01 : 2'b11;
            in_inst   = r;
            in_tag    = {$urandom, $urandom};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cnt_clr   = ($urandom_range(0, 40) == 0);
            cycle();
        end
        cnt_clr = 1'b0;
        out_ready = 1'b1;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
